imem_axi_rd: RTL and testbench
==============================

# imem_axi_rd

Instruction-memory read bridge sitting directly downstream of the instruction fetch unit's memory port. It accepts the fetch unit's single-cycle request pulse (address plus valid) and performs one AXI4-Lite read transaction on the instruction bus. It returns the read word with a single-cycle response pulse. One transaction is in flight at a time; the bridge holds its own copy of the address so the fetch unit may change its PC after the request cycle.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, instruction/data width
- clock  in  1  clock, rising-edge
- reset  in  1  reset, asynchronous, active-high
- io_reqValid  in  1  fetch request pulse (one cycle)
- io_addr  in  ADDR_W  fetch address, sampled only when io_reqValid=1
- io_respValid  out  1  response pulse; io_rdata/io_err valid this cycle only
- io_rdata  out  DATA_W  fetched instruction word
- io_err  out  1  transaction returned non-OKAY rresp
- io_busy  out  1  transaction in progress (state != IDLE)
- m_araddr  out  ADDR_W  AXI read address
- m_arprot  out  3  constant 3'b100 (instruction, secure, unprivileged)
- m_arvalid  out  1  AXI read address valid
- m_arready  in  1  AXI read address ready
- m_rdata  in  DATA_W  AXI read data
- m_rresp  in  2  AXI read response
- m_rvalid  in  1  AXI read data valid
- m_rready  out  1  AXI read data ready

## Operation
- States: IDLE, ADDR, DATA, RESP.
- IDLE: io_reqValid=1 → latch io_addr into addr_q, go ADDR. Otherwise stay.
- ADDR: m_arvalid=1, m_araddr=addr_q. m_arready=1 → go DATA. arvalid stays high and araddr stays stable until the handshake.
- DATA: m_rready=1. m_rvalid=1 → capture m_rdata into rdata_q, capture err_q = (m_rresp != 2'b00), go RESP.
- RESP: io_respValid=1, io_rdata=rdata_q, io_err=err_q. Unconditionally go IDLE.
- io_rdata holds rdata_q in every state. It is stable between responses but meaningful only with io_respValid.
- io_reqValid outside IDLE is ignored; no queueing. The fetch unit never issues one.
- Addresses pass through unaligned. The bridge performs no alignment check.
- rresp SLVERR (2'b10) and DECERR (2'b11) both set io_err. EXOKAY (2'b01) is also treated as an error, because it is illegal on AXI4-Lite.

## Timing
- Reset values: state=IDLE, m_arvalid=0, m_rready=0, io_respValid=0, io_err=0, io_busy=0, io_rdata=0, m_araddr=0, addr_q=0.
- All outputs except m_arprot are decoded from registered state or driven from registers. No combinational path from any input to any output.
- Request sampled at edge N → m_arvalid high from cycle N+1.
- With arready and rvalid both 1 on first assertion: arvalid during cycle N+1, rready during N+2, io_respValid during N+3.
- Minimum request-to-response latency is 3 cycles. Each extra cycle of arready or rvalid wait adds one cycle.
- m_rvalid is never sampled in ADDR, because the bus cannot return data before the address handshake.
- Back-to-back: a new io_reqValid is accepted in the cycle after RESP (IDLE). Peak throughput is one fetch per 4 cycles.
- Reset mid-transaction: return to IDLE immediately and drop arvalid/rready. The interconnect is reset by the same signal, so no transaction is abandoned on the bus.

## Structure
- A shared package (soc_bus_pkg) holds:
  - the AXI response constants RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR;
  - the constant ARPROT_INSTR = 3'b100;
  - the state enum imem_rd_state (IDLE, ADDR, DATA, RESP).
- No sub-module; a single flat FSM with its datapath registers.
- Verilator-only ASCII state debug vector, consistent with other SoC FSMs.

## Test plan
- Zero-wait read: arready=rvalid=1 held, req addr 0x8000_0000, rdata 0x0000_0013, rresp 0.
  - Required: arvalid at N+1 with araddr 0x8000_0000 and arprot 3'b100, rready at N+2.
  - Required: respValid at N+3 with rdata 0x0000_0013, err 0.
- Wait states: arready low 3 cycles, then rvalid low 2 cycles.
  - Required: araddr stable throughout, respValid at N+8, exactly one pulse.
- Address capture: io_addr changes to 0xDEAD_BEEF the cycle after the request at 0x8000_0004.
  - Required: m_araddr = 0x8000_0004.
- Error: rresp=2'b10 with rdata 0x1234_5678.
  - Required: respValid with err=1, rdata 0x1234_5678. The next OKAY read returns err=0.
- Back-to-back: four requests at 0x8000_0000/04/08/0C, each issued in the first IDLE cycle, with zero-wait memory.
  - Required: responses in order, spaced 4 cycles apart, busy=0 only in request cycles.
- Reset asserted in DATA state.
  - Required: arvalid, rready and respValid are 0 asynchronously, state is IDLE, and no response pulse appears after release.

Source files
------------

// File: rtl/soc_bus_pkg.sv
// Shared SoC bus definitions: AXI response codes, protection attributes and
// the instruction-read bridge state encoding.
package soc_bus_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Instruction access, secure, unprivileged.
    localparam logic [2:0] ARPROT_INSTR = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } imem_rd_state;

endpackage

// File: rtl/imem_axi_rd_if.sv
// AXI4-Lite read channels (AR + R) of the instruction bus.
interface imem_axi_rd_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output araddr, arprot, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arprot, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/imem_axi_rd.sv
// Fetch-port to AXI4-Lite read bridge: one request pulse in, one AXI read,
// one response pulse out. Single transaction in flight.
module imem_axi_rd
    import soc_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_reqValid,
    input  logic [ADDR_W-1:0] io_addr,
    output logic              io_respValid,
    output logic [DATA_W-1:0] io_rdata,
    output logic              io_err,
    output logic              io_busy,
    imem_axi_rd_if.master     m
);

    imem_rd_state      state, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // NOTE: state_d gets a default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (io_reqValid) state_d = ADDR;
            ADDR: if (m.arready)   state_d = DATA;
            DATA: if (m.rvalid)    state_d = RESP;
            RESP:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Own copy of the fetch address so the PC may move on after the request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && io_reqValid) addr_q <= io_addr;
            if (state == DATA && m.rvalid) begin
                rdata_q <= m.rdata;
                // EXOKAY is illegal on AXI4-Lite, so anything but OKAY is an error.
                err_q   <= (m.rresp != RESP_OKAY);
            end
        end
    end

    // Every output is a register or a decode of the state register.
    assign m.araddr     = addr_q;
    assign m.arprot     = ARPROT_INSTR;
    assign m.arvalid    = (state == ADDR);
    assign m.rready     = (state == DATA);
    assign io_respValid = (state == RESP);
    assign io_rdata     = rdata_q;
    assign io_err       = err_q;
    assign io_busy      = (state != IDLE);

    // ASCII state name for waveform viewers; not used by the logic.
    logic [8*4-1:0] state_ascii_unused;
    always_comb begin
        case (state)
            IDLE:    state_ascii_unused = "IDLE";
            ADDR:    state_ascii_unused = "ADDR";
            DATA:    state_ascii_unused = "DATA";
            RESP:    state_ascii_unused = "RESP";
            default: state_ascii_unused = "????";
        endcase
    end

endmodule

// File: tb/tb_imem_axi_rd.sv
// Directed self-checking bench for imem_axi_rd: latency, wait states, address
// capture, error responses, back-to-back fetches and mid-transaction reset.
module tb_imem_axi_rd;
    import soc_bus_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_reqValid;
    logic [31:0] io_addr;
    logic        io_respValid;
    logic [31:0] io_rdata;
    logic        io_err;
    logic        io_busy;

    int n_tests = 0;
    int n_fail  = 0;

    imem_axi_rd_if bus ();

    imem_axi_rd dut (
        .clock        (clock),
        .reset        (reset),
        .io_reqValid  (io_reqValid),
        .io_addr      (io_addr),
        .io_respValid (io_respValid),
        .io_rdata     (io_rdata),
        .io_err       (io_err),
        .io_busy      (io_busy),
        .m            (bus.master)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Request pulse sampled at edge N; returns at the negedge inside cycle N+1.
    task automatic issue(input logic [31:0] a, input logic [31:0] a_after);
        @(negedge clock);
        io_reqValid = 1'b1;
        io_addr     = a;
        @(negedge clock);
        io_reqValid = 1'b0;
        io_addr     = a_after;
    endtask

    // Zero-wait read; checks the response lands exactly in cycle N+3.
    task automatic zero_wait_read(input string tag, input logic [31:0] a,
                                  input logic [31:0] d, input logic [1:0] rr,
                                  input logic exp_err);
        bus.arready = 1'b1;
        bus.rvalid  = 1'b1;
        bus.rdata   = d;
        bus.rresp   = rr;
        issue(a, 32'h0);
        @(negedge clock);
        check({tag, "_no_early_resp"}, io_respValid, 1'b0);
        @(negedge clock);
        check({tag, "_resp"}, io_respValid, 1'b1);
        check({tag, "_rdata"}, io_rdata, d);
        check({tag, "_err"}, io_err, exp_err);
        @(negedge clock);
        check({tag, "_resp_drop"}, io_respValid, 1'b0);
    endtask

    int pulses, resp_cyc, ar_cycles;

    initial begin
        reset       = 1'b1;
        io_reqValid = 1'b0;
        io_addr     = 32'h0;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 32'h0;
        bus.rresp   = 2'b00;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_arvalid", bus.arvalid, 1'b0);
        check("rst_rready", bus.rready, 1'b0);
        check("rst_resp", io_respValid, 1'b0);
        check("rst_err", io_err, 1'b0);
        check("rst_busy", io_busy, 1'b0);
        check("rst_rdata", io_rdata, 32'h0);
        check("rst_araddr", bus.araddr, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Zero-wait read with cycle-exact handshake checks
        bus.arready = 1'b1;
        bus.rvalid  = 1'b1;
        bus.rdata   = 32'h0000_0013;
        bus.rresp   = 2'b00;
        issue(32'h8000_0000, 32'h0);
        check("zw_arvalid_n1", bus.arvalid, 1'b1);
        check("zw_araddr_n1", bus.araddr, 32'h8000_0000);
        check("zw_arprot_n1", bus.arprot, 3'b100);
        check("zw_rready_n1", bus.rready, 1'b0);
        check("zw_busy_n1", io_busy, 1'b1);
        @(negedge clock);
        check("zw_rready_n2", bus.rready, 1'b1);
        check("zw_arvalid_n2", bus.arvalid, 1'b0);
        check("zw_resp_n2", io_respValid, 1'b0);
        @(negedge clock);
        check("zw_resp_n3", io_respValid, 1'b1);
        check("zw_rdata_n3", io_rdata, 32'h0000_0013);
        check("zw_err_n3", io_err, 1'b0);
        check("zw_rready_n3", bus.rready, 1'b0);
        @(negedge clock);
        check("zw_resp_n4", io_respValid, 1'b0);
        check("zw_busy_n4", io_busy, 1'b0);

        // Wait states: arready low 3 cycles, rvalid low 2 cycles
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 32'hCAFE_0001;
        issue(32'h8000_0100, 32'h0);
        pulses    = 0;
        resp_cyc  = 0;
        ar_cycles = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge clock);
            if (bus.arvalid) begin
                ar_cycles++;
                check("ws_araddr_stable", bus.araddr, 32'h8000_0100);
            end
            if (io_respValid) begin
                pulses++;
                resp_cyc = c;
                check("ws_rdata", io_rdata, 32'hCAFE_0001);
            end
            bus.arready = (c >= 4);
            bus.rvalid  = (c >= 7);
        end
        check("ws_arvalid_cycles", ar_cycles, 4);
        check("ws_pulse_count", pulses, 1);
        check("ws_resp_cycle", resp_cyc, 8);

        // Address capture: io_addr changes right after the request cycle
        bus.arready = 1'b1;
        bus.rvalid  = 1'b1;
        bus.rdata   = 32'h0000_0093;
        issue(32'h8000_0004, 32'hDEAD_BEEF);
        check("cap_araddr", bus.araddr, 32'h8000_0004);
        repeat (3) @(negedge clock);
        check("cap_idle", io_busy, 1'b0);

        // Error responses, then recovery on OKAY
        zero_wait_read("slverr", 32'h8000_0010, 32'h1234_5678, RESP_SLVERR, 1'b1);
        zero_wait_read("okay_after_err", 32'h8000_0014, 32'h0000_0013, RESP_OKAY, 1'b0);
        zero_wait_read("decerr", 32'h8000_0018, 32'hA5A5_0000, RESP_DECERR, 1'b1);
        zero_wait_read("exokay", 32'h8000_001C, 32'h0F0F_0F0F, RESP_EXOKAY, 1'b1);

        // Back-to-back: requests at t=0,4,8,12, responses at t=3,7,11,15
        bus.arready = 1'b1;
        bus.rvalid  = 1'b1;
        bus.rresp   = RESP_OKAY;
        for (int t = 0; t < 16; t++) begin
            @(negedge clock);
            check("b2b_busy", io_busy, (t % 4) != 0);
            check("b2b_resp", io_respValid, (t % 4) == 3);
            if ((t % 4) == 3)
                check("b2b_rdata", io_rdata, 32'h8000_0100 + 32'((t / 4) * 4));
            bus.rdata = bus.araddr + 32'h100;
            if ((t % 4) == 0) begin
                io_reqValid = 1'b1;
                io_addr     = 32'h8000_0000 + 32'(t);
            end else begin
                io_reqValid = 1'b0;
            end
        end
        @(negedge clock);
        io_reqValid = 1'b0;
        check("b2b_done_idle", io_busy, 1'b0);

        // Reset asserted while in DATA
        bus.arready = 1'b1;
        bus.rvalid  = 1'b0;
        bus.rdata   = 32'h7777_7777;
        issue(32'h8000_0200, 32'h0);
        @(negedge clock);
        check("rd_in_data", bus.rready, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("rd_arvalid", bus.arvalid, 1'b0);
        check("rd_rready", bus.rready, 1'b0);
        check("rd_resp", io_respValid, 1'b0);
        check("rd_state", dut.state, IDLE);
        check("rd_rdata_cleared", io_rdata, 32'h0);
        bus.rvalid = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (io_respValid) pulses++;
            check("rd_post_busy", io_busy, 1'b0);
        end
        check("rd_no_resp_after", pulses, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
